// File: rtl/tt_serial_sub.sv
// tt_serial_sub: bit-serial subtractor computing A - B - Bin, one bit per
// clock, LSB first, with a single borrow flip-flop.
// A start in IDLE captures the operands. RUN lasts WIDTH cycles and streams
// one difference bit per cycle on ser_out/ser_valid. DONE pulses done for
// one cycle and registers the parallel diff/borrow_out.
// Handshake: start is a request sampled only in IDLE, and the operands are
// captured on that same edge. While busy, start and the operand inputs are
// ignored, and start is not queued. done is a one-cycle completion strobe
// with no backpressure.
// Optional feature: define TT_SUB_OVF_EN to add the signed-overflow output ovf.
module tt_serial_sub #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic [WIDTH-1:0] diff,
  output logic             borrow_out,
  output logic             busy,
  output logic             done,
  output logic             ser_out,
`ifdef TT_SUB_OVF_EN
  output logic             ovf,
`endif
  output logic             ser_valid
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  // state is kept as a named enum so checkers can bind to it directly
  state_t           state;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-1:0] diff_sh;
  logic             br;
  logic [CW-1:0]    count;
`ifdef TT_SUB_OVF_EN
  logic             am;
  logic             bm;
`endif

  logic             bit_d;
  logic             br_nxt;
  logic [WIDTH-1:0] diff_nxt;

  // one full-subtractor slice on the current LSBs and the borrow register
  always_comb begin
    bit_d    = a_sh[0] ^ b_sh[0] ^ br;
    br_nxt   = (~a_sh[0] & b_sh[0]) | (~(a_sh[0] ^ b_sh[0]) & br);
    diff_nxt = {bit_d, diff_sh[WIDTH-1:1]};
  end

  // the serial bit is only meaningful while RUN is processing it
  assign ser_valid = (state == RUN);
  assign ser_out   = ser_valid & bit_d;

  // control FSM with all datapath registers and registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      a_sh       <= '0;
      b_sh       <= '0;
      diff_sh    <= '0;
      br         <= 1'b0;
      count      <= '0;
      diff       <= '0;
      borrow_out <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
`ifdef TT_SUB_OVF_EN
      am         <= 1'b0;
      bm         <= 1'b0;
      ovf        <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            a_sh  <= a;
            b_sh  <= b;
            br    <= bin;
            count <= '0;
            busy  <= 1'b1;
            state <= RUN;
`ifdef TT_SUB_OVF_EN
            am    <= a[WIDTH-1];
            bm    <= b[WIDTH-1];
`endif
          end
        end
        RUN: begin
          br      <= br_nxt;
          diff_sh <= diff_nxt;
          a_sh    <= {1'b0, a_sh[WIDTH-1:1]};
          b_sh    <= {1'b0, b_sh[WIDTH-1:1]};
          count   <= count + CW'(1);
          if (count == CW'(WIDTH - 1)) begin
            // last bit: publish the result as DONE is entered
            diff       <= diff_nxt;
            borrow_out <= br_nxt;
            busy       <= 1'b0;
            done       <= 1'b1;
            state      <= DONE;
`ifdef TT_SUB_OVF_EN
            ovf        <= (am != bm) && (bit_d != am);
`endif
          end
        end
        DONE: begin
          done  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_tt_serial_sub.sv
// tb_tt_serial_sub: directed-vector and random-operand bench for
// tt_serial_sub at WIDTH=8, plus a WIDTH=16 instance for random operands.
// Covers the ovf output when TT_SUB_OVF_EN is defined.
module tb_tt_serial_sub;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- DUT signals ----------------
  logic       start8 = 1'b0;
  logic [7:0] a8 = '0, b8 = '0;
  logic       bin8 = 1'b0;
  logic [7:0] diff8;
  logic       bout8, busy8, done8, ser_out8, ser_valid8;

  logic        start16 = 1'b0;
  logic [15:0] a16 = '0, b16 = '0;
  logic        bin16 = 1'b0;
  logic [15:0] diff16;
  logic        bout16, busy16, done16, ser_out16, ser_valid16;
`ifdef TT_SUB_OVF_EN
  logic ovf8, ovf16;
`endif

  tt_serial_sub #(.WIDTH(8)) u8 (
    .clk(clk), .rst(rst), .start(start8), .a(a8), .b(b8), .bin(bin8),
    .diff(diff8), .borrow_out(bout8), .busy(busy8), .done(done8),
    .ser_out(ser_out8),
`ifdef TT_SUB_OVF_EN
    .ovf(ovf8),
`endif
    .ser_valid(ser_valid8)
  );

  tt_serial_sub #(.WIDTH(16)) u16 (
    .clk(clk), .rst(rst), .start(start16), .a(a16), .b(b16), .bin(bin16),
    .diff(diff16), .borrow_out(bout16), .busy(busy16), .done(done16),
    .ser_out(ser_out16),
`ifdef TT_SUB_OVF_EN
    .ovf(ovf16),
`endif
    .ser_valid(ser_valid16)
  );

  // ---------------- scoreboard ----------------
  int checks = 0;
  int errors = 0;
  logic [15:0] exp_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic       bin;
    logic [7:0] ed;
    logic       eb;
    logic       eo;
  } vec_t;

  vec_t vt[10];

  // ---------------- drivers ----------------
  // One WIDTH=8 operation: checks the RUN window, serial stream, latency and result.
  task automatic run_op(input logic [7:0] a, input logic [7:0] b, input logic bin,
                        input logic [7:0] ed, input logic eb, input logic eo);
    int acc;
    logic [7:0] ser;
    logic run_ok;
    @(posedge clk); #1;
    a8 = a; b8 = b; bin8 = bin; start8 = 1'b1;
    @(posedge clk); #1;
    start8 = 1'b0;
    a8 = ~a; b8 = ~b; bin8 = ~bin;
    acc = cyc;
    run_ok = 1'b1;
    for (int k = 0; k < 8; k++) begin
      if (!(busy8 && ser_valid8 && !done8)) run_ok = 1'b0;
      ser[k] = ser_out8;
      @(posedge clk); #1;
    end
    chk("run_window", run_ok, 1'b1);
    chk("ser_stream", ser, ed);
    chk("done_pulse", done8, 1'b1);
    chk("latency", cyc - acc, 8);
    chk("diff", diff8, ed);
    chk("borrow_out", bout8, eb);
    chk("busy_in_done", busy8, 1'b0);
`ifdef TT_SUB_OVF_EN
    chk("ovf", ovf8, eo);
`else
    if (eo === 1'bx) chk("ovf_vec", eo, 1'b0);
`endif
    @(posedge clk); #1;
    chk("done_clear", done8, 1'b0);
  endtask

  // One WIDTH=16 operation: expected result is queued, then popped at done.
  task automatic run16(input logic [15:0] a, input logic [15:0] b, input logic bin);
    int ai, bi, ok;
    ai = int'(a); bi = int'(b);
    exp_q.push_back(16'((ai - bi - int'(bin)) & 32'hFFFF));
    exp_q.push_back({15'd0, (ai < bi + int'(bin))});
    @(posedge clk); #1;
    a16 = a; b16 = b; bin16 = bin; start16 = 1'b1;
    @(posedge clk); #1;
    start16 = 1'b0;
    ok = 0;
    for (int n = 0; n < 40; n++) begin
      if (done16) begin ok = 1; break; end
      @(posedge clk); #1;
    end
    chk("w16_done_seen", ok, 1);
    chk("w16_diff", diff16, exp_q.pop_front());
    chk("w16_borrow", bout16, exp_q.pop_front());
  endtask

  // ---------------- test ----------------
  initial begin
    logic [7:0] ra, rb, rd;
    logic rbin, reb, reo;
    int acc, ok, bad;

    vt[0] = '{8'h5A, 8'h3C, 1'b0, 8'h1E, 1'b0, 1'b0};
    vt[1] = '{8'h00, 8'h01, 1'b0, 8'hFF, 1'b1, 1'b0};
    vt[2] = '{8'h10, 8'h10, 1'b1, 8'hFF, 1'b1, 1'b0};
    vt[3] = '{8'hFF, 8'h00, 1'b0, 8'hFF, 1'b0, 1'b0};
    vt[4] = '{8'h80, 8'h01, 1'b0, 8'h7F, 1'b0, 1'b1};
    vt[5] = '{8'h7F, 8'hFF, 1'b0, 8'h80, 1'b1, 1'b1};
    vt[6] = '{8'h05, 8'h03, 1'b0, 8'h02, 1'b0, 1'b0};
    vt[7] = '{8'h00, 8'h00, 1'b1, 8'hFF, 1'b1, 1'b0};
    vt[8] = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 1'b0};
    vt[9] = '{8'h01, 8'h00, 1'b1, 8'h00, 1'b0, 1'b0};

    // reset state
    #12;
    chk("rst_diff", diff8, 8'h00);
    chk("rst_flags", {bout8, busy8, done8, ser_out8, ser_valid8}, 5'b0);
`ifdef TT_SUB_OVF_EN
    chk("rst_ovf", ovf8, 1'b0);
`endif
    #10 rst = 1'b0;

    // directed table
    for (int i = 0; i < 10; i++)
      run_op(vt[i].a, vt[i].b, vt[i].bin, vt[i].ed, vt[i].eb, vt[i].eo);

    // start held high, operands changed mid-RUN
    @(posedge clk); #1;
    a8 = 8'h33; b8 = 8'h11; bin8 = 1'b0; start8 = 1'b1;
    @(posedge clk); #1;
    acc = cyc;
    chk("hold_busy", busy8, 1'b1);
    repeat (3) @(posedge clk);
    #1;
    a8 = 8'h44; b8 = 8'h01;
    chk("hold_diff_old", diff8, 8'h00);
    ok = 0;
    for (int n = 0; n < 20; n++) begin
      if (done8) begin ok = 1; break; end
      @(posedge clk); #1;
    end
    chk("hold_done_seen", ok, 1);
    chk("hold_latency", cyc - acc, 8);
    chk("hold_diff1", diff8, 8'h22);
    ok = 0;
    for (int n = 0; n < 20; n++) begin
      if (busy8) begin ok = 1; break; end
      @(posedge clk); #1;
    end
    chk("hold_busy2_seen", ok, 1);
    chk("hold_accept_spacing", cyc - acc, 10);
    start8 = 1'b0;
    chk("hold_diff_kept", diff8, 8'h22);
    ok = 0;
    for (int n = 0; n < 20; n++) begin
      if (done8) begin ok = 1; break; end
      @(posedge clk); #1;
    end
    chk("hold_done2_seen", ok, 1);
    chk("hold_diff2", diff8, 8'h43);
    chk("hold_borrow2", bout8, 1'b0);

    // asynchronous reset at RUN cycle 4
    @(posedge clk); #1;
    a8 = 8'h5A; b8 = 8'h3C; bin8 = 1'b0; start8 = 1'b1;
    @(posedge clk); #1;
    start8 = 1'b0;
    repeat (4) @(posedge clk);
    #3 rst = 1'b1;
    #1;
    chk("arst_diff", diff8, 8'h00);
    chk("arst_flags", {bout8, busy8, done8, ser_out8, ser_valid8}, 5'b0);
    @(posedge clk); #3 rst = 1'b0;
    bad = 0;
    for (int n = 0; n < 12; n++) begin
      @(posedge clk); #1;
      if (done8 || busy8) bad = 1;
    end
    chk("arst_no_done", bad, 0);
    run_op(vt[0].a, vt[0].b, vt[0].bin, vt[0].ed, vt[0].eb, vt[0].eo);

    // random operands, WIDTH=8
    for (int i = 0; i < 100; i++) begin
      ra = 8'($urandom_range(0, 255));
      rb = 8'($urandom_range(0, 255));
      rbin = 1'($urandom_range(0, 1));
      rd = 8'((int'(ra) - int'(rb) - int'(rbin)) & 255);
      reb = (int'(ra) < int'(rb) + int'(rbin));
      reo = (ra[7] != rb[7]) && (rd[7] != ra[7]);
      run_op(ra, rb, rbin, rd, reb, reo);
    end

    // random operands, WIDTH=16
    for (int i = 0; i < 100; i++)
      run16(16'($urandom_range(0, 65535)), 16'($urandom_range(0, 65535)),
            1'($urandom_range(0, 1)));

    // ---------------- report ----------------
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/tt_serial_sub.md
Name: tt_serial_sub

Overview:
- Bit-serial subtractor: the inverse-direction companion to the combinational adder tile. It computes A − B − Bin one bit per clock, LSB first, using a single borrow flip-flop.
- It loads parallel operands on a start handshake, streams each difference bit out as it is produced, and presents the parallel difference and final borrow with a one-cycle done pulse.
- It sits beside the adder in the arithmetic tile and is driven by the tile's control logic.

Parameters:
WIDTH, 8, operand/result width in bits (legal range 2..16)

Ports:
clk  input  1  system clock; all state updates on rising edge
rst  input  1  asynchronous, active-high reset
start  input  1  request; sampled only in IDLE
a  input  WIDTH  minuend, captured when start accepted
b  input  WIDTH  subtrahend, captured when start accepted
bin  input  1  borrow-in, captured when start accepted
diff  output  WIDTH  parallel difference; valid when done=1, held until next accepted start
borrow_out  output  1  final borrow; same validity as diff
busy  output  1  high while in RUN
done  output  1  one-cycle pulse in DONE state
ser_out  output  1  difference bit produced this cycle
ser_valid  output  1  high when ser_out is valid (RUN only)

Behaviour:
- Clock and reset: one clock (clk). Reset rst is asynchronous, active-high.
- Reset values: state=IDLE, diff=0, borrow_out=0, busy=0, done=0, ser_out=0, ser_valid=0, count=0, borrow register=0, shift registers=0.
- FSM states: IDLE, RUN, DONE.
  - IDLE: start=1 → capture a into A_sh, b into B_sh, bin into br; count=0; go to RUN. start=0 → stay.
  - RUN: each cycle, with a0=A_sh[0], b0=B_sh[0]:
    - d = a0^b0^br
    - br ← (~a0&b0) | (~(a0^b0)&br)
    - diff shift register ← {d, diff_sh[WIDTH-1:1]}
    - A_sh and B_sh shift right by 1
    - count++
    - When count reaches WIDTH-1 in this cycle, go to DONE.
  - DONE: done=1 for exactly one cycle. diff = diff_sh and borrow_out = br are registered; both outputs update on entry to DONE. Then unconditionally go to IDLE.
- Outputs during RUN:
  - busy=1 for exactly WIDTH cycles.
  - ser_valid=1 with ser_out=d combinationally from the current registers. Bit k appears in RUN cycle k.
- Latency: start sampled at edge t → done high in the cycle after edge t+WIDTH, i.e. WIDTH+1 cycles after acceptance.
- Throughput: one operation per WIDTH+2 cycles (IDLE→RUN×WIDTH→DONE→IDLE).
- start while in RUN or DONE is ignored. It is not queued, and a/b/bin changes are ignored.
- diff and borrow_out retain the previous result through IDLE and RUN of the next operation, and update only on the DONE transition.
- Arithmetic: borrow_out=1 iff unsigned a < b + bin. diff = (a − b − bin) mod 2^WIDTH.
- Reset mid-operation: asynchronous return to reset values. No done pulse. The partial result is discarded.

Optional Feature:
- Macro: TT_SUB_OVF_EN.
- Defined: adds output port ovf (1 bit), signed two's-complement overflow.
  - Captured MSBs am=a[WIDTH-1] and bm=b[WIDTH-1] are held in registers.
  - ovf = (am != bm) && (diff[WIDTH-1] != am).
  - ovf is registered with diff in DONE, holds with diff, and resets to 0.
- Undefined: no ovf port and no MSB-capture registers. All other behaviour is identical.

Test Plan:
- WIDTH=8, a=0x5A, b=0x3C, bin=0, start pulse → busy high 8 cycles; ser_out sequence LSB first 0,1,1,1,1,0,0,0; done at cycle 9 after acceptance; diff=0x1E; borrow_out=0.
- a=0x00, b=0x01, bin=0 → diff=0xFF, borrow_out=1. Then a=0x10, b=0x10, bin=1 → diff=0xFF, borrow_out=1. Then a=0xFF, b=0x00, bin=0 → diff=0xFF, borrow_out=0.
- start held high continuously, a/b changed mid-RUN → only the first capture is used; next op accepted in IDLE after DONE (accept cycles spaced by 10); diff held at the old value until the new DONE.
- rst asserted asynchronously at RUN cycle 4 → all outputs 0 immediately, no done pulse; a fresh start afterwards gives the correct result.
- TT_SUB_OVF_EN defined: a=0x80, b=0x01 → diff=0x7F, ovf=1, borrow_out=0. a=0x7F, b=0xFF → diff=0x80, ovf=1, borrow_out=1. a=0x05, b=0x03 → ovf=0.
- Randomized-operand check over 200 ops (WIDTH=8 and WIDTH=16) against the reference model (a−b−bin) → diff and borrow_out match every done pulse.
